// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: sequencer that owns a WIDTH-bit down counter.
// A preload value is accepted over a valid/ready handshake. The count then
// runs on command at a rate set by a prescaler. It can be paused, resumed or
// aborted, and done pulses for one cycle when the count expires.
// Optional feature macro: DCNT_AUTO_RELOAD_EN. When it is defined, the
// sequencer reloads the last accepted preload after every done and keeps
// running until abort or rst.
// All outputs are registered. rst is synchronous and active-high.

module down_counter_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  // The prescaler counts 0 .. PRESCALE-1. A tick happens on its last value.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [PW-1:0]    PRE_ZERO = {PW{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_INIT = {WIDTH{1'b1}};

`ifdef DCNT_AUTO_RELOAD_EN
  localparam logic AUTO_RELOAD = 1'b1;
`else
  localparam logic AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic [PW-1:0]    pre_r;
  logic [PW-1:0]    pre_s;
  logic             done_r;
  logic             done_s;
  logic             busy_r;
  logic             busy_s;
  logic             ready_r;
  logic             ready_s;
  logic             handshake_s;
  logic [WIDTH-1:0] reload_s;

  // True when the prescaler sits on its final value, so the next run cycle decrements.
  function automatic logic is_tick(input logic [PW-1:0] pre);
    return (pre == PRE_LAST);
  endfunction

  // Busy covers RUN and HOLD. With auto-reload it also covers the DONE cycle.
  function automatic logic busy_of(input state_t st);
    logic b;
    case (st)
      S_RUN:   b = 1'b1;
      S_HOLD:  b = 1'b1;
      S_DONE:  b = AUTO_RELOAD;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  // A preload can only be accepted while the counter is not running.
  function automatic logic ready_of(input state_t st);
    logic r;
    case (st)
      S_IDLE:  r = 1'b1;
      S_ARMED: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef DCNT_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_r;

  // The reload register follows every accepted preload.
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_r <= CNT_ZERO;
    end else if (handshake_s) begin
      reload_r <= load_value;
    end else begin
      reload_r <= reload_r;
    end
  end

  assign reload_s = reload_r;
`else
  assign reload_s = CNT_ZERO;
`endif

  // The handshake is qualified by the registered ready, which is exactly what the host sees.
  assign handshake_s = load_valid && ready_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and next datapath values. Priority is abort > pause > tick.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    pre_s   = pre_r;
    done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        // start, pause and abort have no effect here.
        if (handshake_s) begin
          count_s = load_value;
          state_s = S_ARMED;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (handshake_s) begin
          // A new load replaces the armed value. A coincident start is dropped.
          count_s = load_value;
          state_s = S_ARMED;
        end else if (start) begin
          pre_s   = PRE_ZERO;
          state_s = S_RUN;
        end else begin
          state_s = S_ARMED;
        end
      end
      S_RUN, S_HOLD: begin
        // Leaving HOLD counts as a normal run cycle, so the prescaler resumes
        // on the release edge. The delay then equals the cycles paused.
        if (abort) begin
          state_s = S_IDLE;
        end else if (pause) begin
          state_s = S_HOLD;
        end else if (count_r == CNT_ZERO) begin
          done_s  = 1'b1;
          state_s = S_DONE;
        end else if (is_tick(pre_r)) begin
          count_s = count_r - CNT_ONE;
          pre_s   = PRE_ZERO;
          state_s = S_RUN;
        end else begin
          pre_s   = pre_r + PRE_ONE;
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_s = S_IDLE;
        end else if (AUTO_RELOAD) begin
          count_s = reload_s;
          pre_s   = PRE_ZERO;
          state_s = S_RUN;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    busy_s  = busy_of(state_s);
    ready_s = ready_of(state_s);
  end

  // Datapath and output registers. Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= CNT_INIT;
      pre_r   <= PRE_ZERO;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      count_r <= count_s;
      pre_r   <= pre_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
      ready_r <= ready_s;
    end
  end

  assign count      = count_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign load_ready = ready_r;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Self-checking bench for down_counter_ctrl.
// Two instances share one stimulus: u_p1 uses PRESCALE=1 and u_p3 uses PRESCALE=3.
// Directed scenarios check fixed values. A random phase compares both
// instances every cycle against a behavioural model in which RUN and HOLD
// are one "active" phase where pause simply freezes time.
// Honours DCNT_AUTO_RELOAD_EN in the same way as the design.

module tb_down_counter_ctrl;
  localparam int W = 4;

`ifdef DCNT_AUTO_RELOAD_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         start;
  logic         pause;
  logic         abort;
  logic [W-1:0] count1;
  logic [W-1:0] count3;
  logic         busy1;
  logic         busy3;
  logic         done1;
  logic         done3;
  logic         ready1;
  logic         ready3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  down_counter_ctrl #(.WIDTH(W), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready1),
    .load_value(load_value), .start(start), .pause(pause), .abort(abort),
    .count(count1), .busy(busy1), .done(done1)
  );

  down_counter_ctrl #(.WIDTH(W), .PRESCALE(3)) u_p3 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready3),
    .load_value(load_value), .start(start), .pause(pause), .abort(abort),
    .count(count3), .busy(busy3), .done(done3)
  );

  // Behavioural model: index 0 tracks u_p1, index 1 tracks u_p3.
  localparam int M_IDLE = 0, M_ARMED = 1, M_ACTIVE = 2, M_DONE = 3;
  int m_mode[2];
  int m_cnt[2];
  int m_pre[2];
  int m_done[2];
  int m_reload[2];

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int p;
      bit hs;
      p  = (i == 0) ? 1 : 3;
      hs = load_valid && (m_mode[i] == M_IDLE || m_mode[i] == M_ARMED);
      if (rst) begin
        m_mode[i] = M_IDLE; m_cnt[i] = 15; m_pre[i] = 0; m_done[i] = 0; m_reload[i] = 0;
      end else begin
        m_done[i] = 0;
        if (hs) m_reload[i] = load_value;
        if (m_mode[i] == M_IDLE) begin
          if (hs) begin m_cnt[i] = load_value; m_mode[i] = M_ARMED; end
        end else if (abort) begin
          m_mode[i] = M_IDLE;
        end else if (m_mode[i] == M_ARMED) begin
          if (hs) m_cnt[i] = load_value;
          else if (start) begin m_mode[i] = M_ACTIVE; m_pre[i] = 0; end
        end else if (m_mode[i] == M_ACTIVE) begin
          if (!pause) begin
            if (m_cnt[i] == 0) begin
              m_mode[i] = M_DONE; m_done[i] = 1;
            end else begin
              m_pre[i] = m_pre[i] + 1;
              if (m_pre[i] == p) begin m_pre[i] = 0; m_cnt[i] = m_cnt[i] - 1; end
            end
          end
        end else begin
          if (AUTO) begin m_mode[i] = M_ACTIVE; m_cnt[i] = m_reload[i]; m_pre[i] = 0; end
          else m_mode[i] = M_IDLE;
        end
      end
    end
  endtask

  // One clock edge. The model follows the same inputs, then outputs are sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic flush();
    abort = 1'b1; cycle(); abort = 1'b0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_value = v; load_valid = 1'b1; cycle(); load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    checks++; if (count1 !== 4'hF || count3 !== 4'hF) begin failures++;
      $display("FAIL reset_count: got %h/%h expected f", count1, count3); end
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin failures++;
      $display("FAIL reset_busy: got %b/%b expected 0", busy1, busy3); end
    checks++; if (done1 !== 1'b0 || done3 !== 1'b0) begin failures++;
      $display("FAIL reset_done: got %b/%b expected 0", done1, done3); end
    checks++; if (ready1 !== 1'b1 || ready3 !== 1'b1) begin failures++;
      $display("FAIL reset_ready: got %b/%b expected 1", ready1, ready3); end
  endtask

  task automatic test_prescale1();
    logic [W-1:0] exp;
    flush(); do_load(4'd5);
    checks++; if (count1 !== 4'd5 || busy1 !== 1'b0 || ready1 !== 1'b1) begin failures++;
      $display("FAIL p1_armed: got cnt=%0d busy=%b rdy=%b expected 5/0/1", count1, busy1, ready1); end
    start = 1'b1; cycle(); start = 1'b0;
    checks++; if (count1 !== 4'd5 || busy1 !== 1'b1 || ready1 !== 1'b0) begin failures++;
      $display("FAIL p1_start: got cnt=%0d busy=%b rdy=%b expected 5/1/0", count1, busy1, ready1); end
    for (int j = 1; j <= 5; j++) begin
      cycle(); exp = W'(5 - j);
      checks++; if (count1 !== exp || done1 !== 1'b0) begin failures++;
        $display("FAIL p1_count step %0d: got cnt=%0d done=%b expected %0d/0", j, count1, done1, exp); end
    end
    cycle();
    checks++; if (done1 !== 1'b1 || count1 !== 4'd0 || busy1 !== AUTO) begin failures++;
      $display("FAIL p1_done: got done=%b cnt=%0d busy=%b expected 1/0/%b", done1, count1, busy1, AUTO); end
    cycle(); exp = AUTO ? 4'd5 : 4'd0;
    checks++; if (done1 !== 1'b0 || count1 !== exp || busy1 !== AUTO || ready1 !== !AUTO) begin
      failures++;
      $display("FAIL p1_after: got done=%b cnt=%0d busy=%b rdy=%b expected 0/%0d/%b/%b",
               done1, count1, busy1, ready1, exp, AUTO, !AUTO); end
  endtask

  task automatic test_prescale3();
    logic [W-1:0] exp;
    logic         exp_done;
    flush(); do_load(4'd2);
    start = 1'b1; cycle(); start = 1'b0;
    checks++; if (count3 !== 4'd2 || busy3 !== 1'b1) begin failures++;
      $display("FAIL p3_start: got cnt=%0d busy=%b expected 2/1", count3, busy3); end
    for (int j = 1; j <= 7; j++) begin
      cycle();
      exp      = (j < 3) ? 4'd2 : ((j < 6) ? 4'd1 : 4'd0);
      exp_done = (j == 7);
      checks++; if (count3 !== exp || done3 !== exp_done) begin failures++;
        $display("FAIL p3_step %0d: got cnt=%0d done=%b expected %0d/%b", j, count3, done3, exp, exp_done); end
    end
  endtask

  task automatic test_pause();
    logic [W-1:0] exp;
    flush(); do_load(4'd6);
    start = 1'b1; cycle(); start = 1'b0;
    for (int j = 1; j <= 3; j++) cycle();
    checks++; if (count1 !== 4'd3) begin failures++;
      $display("FAIL pause_pre: got %0d expected 3", count1); end
    pause = 1'b1;
    for (int j = 4; j <= 7; j++) begin
      cycle();
      checks++; if (count1 !== 4'd3 || busy1 !== 1'b1 || done1 !== 1'b0) begin failures++;
        $display("FAIL pause_hold %0d: got cnt=%0d busy=%b done=%b expected 3/1/0", j, count1, busy1, done1); end
    end
    pause = 1'b0;
    for (int j = 8; j <= 10; j++) begin
      cycle(); exp = W'(10 - j);
      checks++; if (count1 !== exp || done1 !== 1'b0) begin failures++;
        $display("FAIL pause_resume %0d: got cnt=%0d done=%b expected %0d/0", j, count1, done1, exp); end
    end
    cycle();
    checks++; if (done1 !== 1'b1) begin failures++;
      $display("FAIL pause_done: got %b expected 1", done1); end
  endtask

  task automatic test_abort();
    logic [W-1:0] exp;
    flush(); do_load(4'd9);
    start = 1'b1; cycle(); start = 1'b0;
    load_valid = 1'b1; load_value = 4'd7;
    for (int j = 1; j <= 5; j++) begin
      cycle(); exp = W'(9 - j);
      checks++; if (ready1 !== 1'b0 || count1 !== exp) begin failures++;
        $display("FAIL abort_run %0d: got rdy=%b cnt=%0d expected 0/%0d", j, ready1, count1, exp); end
    end
    load_valid = 1'b0; abort = 1'b1; cycle(); abort = 1'b0;
    checks++; if (count1 !== 4'd4 || busy1 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got cnt=%0d busy=%b rdy=%b done=%b expected 4/0/1/0",
               count1, busy1, ready1, done1); end
    for (int j = 0; j < 12; j++) begin
      cycle();
      checks++; if (done1 !== 1'b0 || count1 !== 4'd4) begin failures++;
        $display("FAIL abort_quiet %0d: got done=%b cnt=%0d expected 0/4", j, done1, count1); end
    end
  endtask

  task automatic test_armed();
    flush();
    start = 1'b1; pause = 1'b1; cycle(); start = 1'b0; pause = 1'b0;
    checks++; if (busy1 !== 1'b0 || ready1 !== 1'b1) begin failures++;
      $display("FAIL idle_ignore: got busy=%b rdy=%b expected 0/1", busy1, ready1); end
    do_load(4'd5);
    load_value = 4'd2; load_valid = 1'b1; start = 1'b1; cycle(); load_valid = 1'b0;
    checks++; if (count1 !== 4'd2 || busy1 !== 1'b0 || ready1 !== 1'b1) begin failures++;
      $display("FAIL load_beats_start: got cnt=%0d busy=%b rdy=%b expected 2/0/1", count1, busy1, ready1); end
    cycle(); start = 1'b0;
    checks++; if (busy1 !== 1'b1 || count1 !== 4'd2) begin failures++;
      $display("FAIL armed_start: got busy=%b cnt=%0d expected 1/2", busy1, count1); end
    cycle(); cycle(); cycle();
    checks++; if (done1 !== 1'b1 || count1 !== 4'd0) begin failures++;
      $display("FAIL armed_done: got done=%b cnt=%0d expected 1/0", done1, count1); end
  endtask

  task automatic test_reset_mid();
    flush(); do_load(4'd9);
    start = 1'b1; cycle(); start = 1'b0;
    cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    checks++; if (count1 !== 4'hF || busy1 !== 1'b0 || done1 !== 1'b0 || ready1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: got cnt=%h busy=%b done=%b rdy=%b expected f/0/0/1",
               count1, busy1, done1, ready1); end
  endtask

  task automatic test_auto_reload();
    logic exp_done;
    flush(); do_load(4'd3);
    start = 1'b1; cycle(); start = 1'b0;
    for (int j = 1; j <= 15; j++) begin
      cycle();
      exp_done = (j >= 4) && ((j - 4) % 5 == 0);
      checks++; if (done1 !== exp_done) begin failures++;
        $display("FAIL auto_done %0d: got %b expected %b", j, done1, exp_done); end
      if (j == 5) begin
        checks++; if (count1 !== 4'd3 || busy1 !== 1'b1) begin failures++;
          $display("FAIL auto_reload: got cnt=%0d busy=%b expected 3/1", count1, busy1); end
      end
    end
    abort = 1'b1; cycle(); abort = 1'b0;
    for (int j = 0; j < 10; j++) begin
      cycle();
      checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin failures++;
        $display("FAIL auto_abort %0d: got busy=%b done=%b expected 0/0", j, busy1, done1); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a_cnt;
    logic         a_busy;
    logic         a_done;
    logic         a_rdy;
    logic         e_busy;
    logic         e_rdy;
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      load_valid = ($urandom_range(0, 5) == 0);
      load_value = W'($urandom_range(0, 15));
      start      = ($urandom_range(0, 2) == 0);
      pause      = ($urandom_range(0, 5) == 0);
      abort      = ($urandom_range(0, 89) == 0);
      cycle();
      for (int i = 0; i < 2; i++) begin
        a_cnt  = (i == 0) ? count1 : count3;
        a_busy = (i == 0) ? busy1  : busy3;
        a_done = (i == 0) ? done1  : done3;
        a_rdy  = (i == 0) ? ready1 : ready3;
        e_busy = (m_mode[i] == M_ACTIVE) || (AUTO && m_mode[i] == M_DONE);
        e_rdy  = (m_mode[i] == M_IDLE) || (m_mode[i] == M_ARMED);
        checks++; if (a_cnt !== W'(m_cnt[i])) begin failures++;
          $display("FAIL rand_count inst%0d cyc%0d: got %0d expected %0d", i, n, a_cnt, m_cnt[i]); end
        checks++; if (a_done !== m_done[i][0]) begin failures++;
          $display("FAIL rand_done inst%0d cyc%0d: got %b expected %0d", i, n, a_done, m_done[i]); end
        checks++; if (a_busy !== e_busy) begin failures++;
          $display("FAIL rand_busy inst%0d cyc%0d: got %b expected %b", i, n, a_busy, e_busy); end
        checks++; if (a_rdy !== e_rdy) begin failures++;
          $display("FAIL rand_ready inst%0d cyc%0d: got %b expected %b", i, n, a_rdy, e_rdy); end
      end
    end
    rst = 1'b0; load_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_IDLE; m_cnt[i] = 15; m_pre[i] = 0; m_done[i] = 0; m_reload[i] = 0;
    end
    test_reset();
    test_prescale1();
    test_prescale3();
    test_pause();
    test_abort();
    test_armed();
    test_reset_mid();
`ifdef DCNT_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
